// File: rtl/sreg_8b_sipo_deser.sv
// ---------------------------------------------------------------------------
// sreg_8b_sipo_deser
//
// Serial-in, parallel-out deserializer, companion to the 8-bit PISO shift
// register. Bits arrive MSB-first, one per enabled cycle. Every eighth
// enabled bit completes a word. The word is presented on a single-entry
// valid/ready holding register, so a downstream consumer can stall without
// losing the word in flight. A sticky overrun flag records any word that
// completed while the previous word was still undelivered.
//
// Ports:
//   clk      in   1  clock; all state updates on posedge
//   reset    in   1  synchronous, active-high reset (clears everything)
//   clr      in   1  frame realign: drop the partial word, restart bit count
//   en       in   1  sample sin this cycle
//   sin      in   1  serial data bit (MSB of each word first)
//   out_val  out  1  pout holds a completed, undelivered word
//   out_rdy  in   1  consumer takes pout when out_val & out_rdy
//   pout     out  8  completed word; bit 7 = first bit received
//   overrun  out  1  sticky: a completed word was dropped (cleared by reset)
//
// Priority at each edge: reset > clr > en. All outputs are registered.
// ---------------------------------------------------------------------------
module sreg_8b_sipo_deser (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       sin,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] pout,
    output logic       overrun
);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Bit counter advance; the 3-bit width gives the 7 -> 0 wrap for free.
    function automatic logic [2:0] cnt_next(input logic [2:0] c);
        return c + 3'd1;
    endfunction

    // MSB-first shift: the oldest bit moves toward bit 7.
    function automatic logic [7:0] shift_in(input logic [7:0] s, input logic b);
        return {s[6:0], b};
    endfunction

    // -----------------------------------------------------------------------
    // Receive state
    // -----------------------------------------------------------------------
    logic [7:0] sreg;
    logic [2:0] cnt;

    // -----------------------------------------------------------------------
    // Per-cycle decode
    // -----------------------------------------------------------------------
    logic       shift_en;   // a bit is accepted into the shift register
    logic       complete;   // this bit finishes a word
    logic       drain;      // consumer takes the pending word
    logic       can_load;   // holding register is free, or frees this cycle
    logic       load;       // completed word goes into the holding register
    logic       drop;       // completed word is lost; overrun sets
    logic [7:0] word;       // the word that completes this cycle

    always_comb begin
        // clr in the same cycle masks the bit, so it also masks completion.
        shift_en = en & ~clr;
        complete = shift_en & (cnt == 3'd7);
        word     = shift_in(sreg, sin);

        // out_rdy only matters while a word is pending.
        drain    = out_val & out_rdy;

        // A free register, or one emptied this cycle, accepts the new word.
        // This allows a drain and a refill on the same edge.
        can_load = ~out_val | out_rdy;
        load     = complete & can_load;
        drop     = complete & ~can_load;
    end

    // -----------------------------------------------------------------------
    // Shift register and bit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= 8'h00;
            cnt  <= 3'd0;
        end else if (clr) begin
            sreg <= 8'h00;
            cnt  <= 3'd0;
        end else if (en) begin
            sreg <= word;
            cnt  <= cnt_next(cnt);
        end
    end

    // -----------------------------------------------------------------------
    // Holding register and output handshake
    // -----------------------------------------------------------------------
    // clr does not reach this block. A pending word survives a realign, and
    // the handshake runs normally on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pout    <= 8'h00;
            out_val <= 1'b0;
        end else if (load) begin
            pout    <= word;
            out_val <= 1'b1;
        end else if (drain) begin
            // pout keeps its last value; it is don't-care while out_val = 0.
            out_val <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky overrun
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sreg_8b_sipo_deser.sv
module tb_sreg_8b_sipo_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       en;
    logic       sin;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] pout;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] piso;
    logic [7:0] lb_vec [3];

    sreg_8b_sipo_deser dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (en),
        .sin     (sin),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .pout    (pout),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        en      = 1'b1;
        sin     = b;
        out_rdy = rdy;
        tick();
    endtask

    // Sends bits [7:first_stop] of w MSB-first. An idle cycle follows each
    // bit when gap is set.
    task automatic send_bits(input logic [7:0] w, input int n, input logic rdy, input logic gap);
        for (int i = 7; i > 7 - n; i--) begin
            send_bit(w[i], rdy);
            if (gap) begin
                en = 1'b0;
                tick();
            end
        end
    endtask

    task automatic idle(input logic rdy);
        en      = 1'b0;
        out_rdy = rdy;
        tick();
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; en = 1'b1; sin = 1'b1; out_rdy = 1'b1;
        piso  = 8'h00;

        // Reset held for two cycles, with en/sin active.
        tick();
        tick();
        chk1("rst_val", out_val, 1'b0);
        chk8("rst_pout", pout, 8'h00);
        chk1("rst_ovr", overrun, 1'b0);
        reset = 1'b0;
        idle(1'b1);
        chk1("rst_noword", out_val, 1'b0);

        // Single word A5
        send_bits(8'hA5, 7, 1'b1, 1'b0);
        chk1("a5_bit7_noval", out_val, 1'b0);
        send_bit(1'b1, 1'b1);
        chk1("a5_val", out_val, 1'b1);
        chk8("a5_pout", pout, 8'hA5);
        idle(1'b1);
        chk1("a5_drained", out_val, 1'b0);

        // Partial bits, clr with en=1, then gapped 3C
        out_rdy = 1'b0;
        send_bits(8'hFF, 3, 1'b0, 1'b0);
        clr = 1'b1; en = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0;
        send_bits(8'h3C, 8, 1'b0, 1'b1);
        chk1("3c_val", out_val, 1'b1);
        chk8("3c_pout", pout, 8'h3C);
        clr = 1'b1;
        idle(1'b0);
        clr = 1'b0;
        chk1("clr_keep_val", out_val, 1'b1);
        chk8("clr_keep_pout", pout, 8'h3C);
        idle(1'b1);
        chk1("3c_drained", out_val, 1'b0);

        // Back-to-back: stall on 12, drain and refill with 34 on one edge
        send_bits(8'h12, 8, 1'b0, 1'b0);
        chk1("12_val", out_val, 1'b1);
        chk8("12_pout", pout, 8'h12);
        send_bits(8'h34, 7, 1'b0, 1'b0);
        chk8("12_held", pout, 8'h12);
        send_bit(1'b0, 1'b1);
        chk1("34_val", out_val, 1'b1);
        chk8("34_pout", pout, 8'h34);
        chk1("34_no_ovr", overrun, 1'b0);
        idle(1'b1);
        chk1("34_drained", out_val, 1'b0);

        // Overrun: 55 then AA with the consumer stalled
        send_bits(8'h55, 8, 1'b0, 1'b0);
        chk8("55_pout", pout, 8'h55);
        send_bits(8'hAA, 7, 1'b0, 1'b0);
        chk1("ovr_before", overrun, 1'b0);
        send_bit(1'b0, 1'b0);
        chk1("ovr_set", overrun, 1'b1);
        chk8("ovr_pout55", pout, 8'h55);
        chk1("ovr_val", out_val, 1'b1);
        clr = 1'b1;
        idle(1'b0);
        clr = 1'b0;
        chk1("ovr_after_clr", overrun, 1'b1);
        idle(1'b1);
        chk1("ovr_drain_val", out_val, 1'b0);
        chk1("ovr_after_drain", overrun, 1'b1);
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        chk1("ovr_reset", overrun, 1'b0);

        // Reset after 5 bits, then a fresh F0
        send_bits(8'hFF, 5, 1'b1, 1'b0);
        reset = 1'b1; en = 1'b1; sin = 1'b1;
        tick();
        reset = 1'b0;
        send_bits(8'hF0, 7, 1'b1, 1'b0);
        chk1("f0_bit7_noval", out_val, 1'b0);
        send_bit(1'b0, 1'b1);
        chk1("f0_val", out_val, 1'b1);
        chk8("f0_pout", pout, 8'hF0);
        idle(1'b1);

        // clr coinciding with the 8th bit suppresses completion
        send_bits(8'hFF, 7, 1'b1, 1'b0);
        clr = 1'b1; en = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0;
        chk1("clr_cmpl_noval", out_val, 1'b0);
        chk1("clr_cmpl_noovr", overrun, 1'b0);

        // Loopback through a PISO model sharing en
        lb_vec[0] = 8'h81; lb_vec[1] = 8'h7E; lb_vec[2] = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            en = 1'b0; out_rdy = 1'b1;
            tick();
            piso = lb_vec[k];
            for (int i = 0; i < 8; i++) begin
                send_bit(piso[7], 1'b1);
                piso = {piso[6:0], 1'b0};
            end
            chk1("lb_val", out_val, 1'b1);
            chk8("lb_pout", pout, lb_vec[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sreg_8b_sipo_deser.md
# sreg_8b_sipo_deser

Serial-in, parallel-out deserializer that pairs with the team's 8-bit PISO shift register. It accepts a bit stream MSB-first, one bit per enabled cycle, and assembles each 8-bit word. It presents each completed word on a single-entry valid/ready output port, so a downstream consumer can stall without losing the word in flight. It also reports a sticky overrun when a new word completes while the previous one is still undelivered.

## Interface
- Parameters: none (fixed 8-bit word, MSB-first).
- `clk      input   1  clock; all state updates on posedge`
- `reset    input   1  synchronous, active-high reset`
- `clr      input   1  frame realign: discard partial word, restart bit count`
- `en       input   1  sample `sin` this cycle`
- `sin      input   1  serial data bit (wire directly from the PISO `sout`)`
- `out_val  output  1  `pout` holds a completed, undelivered word`
- `out_rdy  input   1  consumer accepts `pout` when `out_val & out_rdy``
- `pout     output  8  completed word; bit 7 = first bit received`
- `overrun  output  1  sticky: a completed word was dropped`

## Operation
- Internal state:
  - `sreg[7:0]` is the shift register.
  - `cnt[2:0]` holds bits received in the current word (0–7).
  - `pout[7:0]` and `out_val` form the holding register.
  - `overrun` is a sticky flag.
- Priority at each posedge is `reset` > `clr` > `en`.
- `reset`: `sreg`=0, `cnt`=0, `pout`=8'h00, `out_val`=0, `overrun`=0. This applies even mid-word or with a word pending; a pending word is lost.
- `clr` (no reset):
  - `sreg`=0 and `cnt`=0.
  - `sin` is ignored that cycle, even if `en`=1.
  - The holding register, `out_val` and `overrun` are unaffected; the output handshake proceeds normally.
- `en` (no reset, no clr):
  - `sreg` <= {`sreg[6:0]`, `sin`}.
  - `cnt` <= `cnt`+1, wrapping 7→0.
- Word completion happens when `en` and `cnt`==7. The completed word is {`sreg[6:0]`, `sin`}.
  - If `out_val`==0, or `out_val & out_rdy` this cycle: `pout` <= word and `out_val` <= 1. Simultaneous drain and refill is allowed, so back-to-back words need no bubble.
  - Otherwise the word is dropped, `pout`/`out_val` are unchanged, and `overrun` <= 1.
  - In both cases `cnt` wraps to 0 and reception continues.
- Drain with no completion: when `out_val & out_rdy`, `out_val` <= 0 and `pout` holds its last value (don't-care).
- `out_rdy` is ignored while `out_val`=0. `out_val` never depends combinationally on `out_rdy`.
- `overrun` stays at 1 until `reset`; `clr` does not clear it.
- `en`=0 freezes `sreg` and `cnt`. Gaps between bits are legal.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Latency: the 8th enabled bit is sampled at edge N, and `out_val`=1 with `pout` valid after edge N.
- System pairing: the PISO loads `pin` at edge 0. Both blocks then see `en`=1 on the same 8 cycles, edges 1–8, and `pout`==`pin` after edge 8.
- Sustained throughput is 1 word per 8 enabled cycles, provided the consumer accepts within 8 cycles of `out_val` rising.
- `reset` or `clr` asserted in the same cycle as completion suppresses that completion. No load and no overrun occur.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `en`=1 and `sin`=1 → `out_val`=0, `pout`=8'h00, `overrun`=0, and no word appears.
- **Single word:** `out_rdy`=1, `en`=1 for 8 cycles, `sin` = 1,0,1,0,0,1,0,1 → after the 8th edge `out_val`=1 and `pout`=8'hA5; next cycle `out_val`=0.
- **Gapped bits plus clr:**
  - Send 3 bits of 1, assert `clr`, then send 8'h3C with `en` toggling 1,0 → `pout`=8'h3C exactly; the partial bits are discarded.
  - Assert `clr` with `out_val`=1 → the pending word and `out_val` are untouched.
- **Back-to-back with stall:**
  - Hold `out_rdy`=0 and send 8'h12 → `out_val`=1 and `pout` holds 8'h12.
  - Raise `out_rdy` on the exact cycle the next word 8'h34 completes → `pout`=8'h34, `out_val` stays 1, `overrun`=0.
- **Overrun:**
  - Hold `out_rdy`=0 and send 8'h55 then 8'hAA → `pout`=8'h55 and `overrun`=1 after the 16th bit; `overrun` stays 1 through `clr` and drain, and clears only on `reset`.
  - A reset mid-word after 5 bits, followed by a fresh word 8'hF0 → `pout`=8'hF0.
- **Loopback:** drive the PISO with `pin` = 8'h81, 8'h7E, 8'hC3 and share `en` → each `pout` matches its `pin` 8 enabled cycles after load.
